// File: rtl/key_count_pkg.sv
// Shared types for the key_count_source slice: debounce state
// encoding and the width of the displayed count.
package key_count_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    DB_IDLE       = 2'd0,
    DB_WAIT_PRESS = 2'd1,
    DB_PRESSED    = 2'd2,
    DB_WAIT_REL   = 2'd3
  } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-flop synchronizer, debounce FSM,
// one-cycle registered press pulse. DEBOUNCE_CYCLES must be >= 2.
module key_debounce
  import key_count_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // IDLE/PRESSED supply the first stable sample, so the
  // wait states only need DEBOUNCE_CYCLES-1 more.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic      r_s1;
  logic      r_s2;
  db_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic      r_press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_key_n;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      unique case (r_state)
        DB_IDLE: begin
          if (!r_s2) begin
            r_state <= DB_WAIT_PRESS;
            r_cnt   <= '0;
          end
        end
        DB_WAIT_PRESS: begin
          if (r_s2) begin
            r_state <= DB_IDLE;
          end else if (r_cnt == LAST) begin
            r_state <= DB_PRESSED;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DB_PRESSED: begin
          if (r_s2) begin
            r_state <= DB_WAIT_REL;
            r_cnt   <= '0;
          end
        end
        DB_WAIT_REL: begin
          if (!r_s2) begin
            r_state <= DB_PRESSED;
          end else if (r_cnt == LAST) begin
            r_state <= DB_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= DB_IDLE;
      endcase
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/key_count_source.sv
// Debounced inc/dec/load keys drive a wrapping 0..MAX_VALUE count.
// KEY_COUNT_AUTO_RUN_EN adds a RUN-gated periodic increment tick.
module key_count_source
  import key_count_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_VALUE       = 15,
  parameter int TICK_CYCLES     = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       KEY_INC,
  input  logic       KEY_DEC,
  input  logic       KEY_LOAD,
  input  logic [3:0] SW,
  input  logic       RUN,
  output logic [3:0] V,
  output logic       CHG
);

  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_VALUE);

  logic w_inc;
  logic w_dec;
  logic w_load;
  logic w_tick;
  logic [CNT_W-1:0] w_next;
  logic [CNT_W-1:0] w_sw_sat;
  logic [CNT_W-1:0] r_v;
  logic             r_chg;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .i_clk   (CLOCK_50),
    .i_rst_n (Resetn),
    .i_key_n (KEY_INC),
    .o_press (w_inc)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .i_clk   (CLOCK_50),
    .i_rst_n (Resetn),
    .i_key_n (KEY_DEC),
    .o_press (w_dec)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .i_clk   (CLOCK_50),
    .i_rst_n (Resetn),
    .i_key_n (KEY_LOAD),
    .o_press (w_load)
  );

`ifdef KEY_COUNT_AUTO_RUN_EN
  localparam int TW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] r_tick_cnt;

  assign w_tick = RUN && (r_tick_cnt == TLAST);

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_tick_cnt <= '0;
    end else if (!RUN || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end
`else
  logic w_unused_run;
  assign w_unused_run = RUN;
  assign w_tick = 1'b0;
`endif

  assign w_sw_sat = (SW > MAXV) ? MAXV : SW;

  // Tick sits below every key pulse, including inc+dec cancel.
  always_comb begin
    w_next = r_v;
    if (w_load) begin
      w_next = w_sw_sat;
    end else if (w_inc && w_dec) begin
      w_next = r_v;
    end else if (w_inc || (w_tick && !w_dec)) begin
      w_next = (r_v == MAXV) ? '0 : r_v + 1'b1;
    end else if (w_dec) begin
      w_next = (r_v == '0) ? MAXV : r_v - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_v   <= '0;
      r_chg <= 1'b0;
    end else begin
      r_v   <= w_next;
      r_chg <= (w_next != r_v);
    end
  end

  assign V   = r_v;
  assign CHG = r_chg;

endmodule

// File: tb/tb_key_count_source.sv
// Directed plus random bench for key_count_source against a
// run-length debounce model; two instances (MAX 15 and MAX 9).
module tb_key_count_source;

  localparam int DB = 4;
  localparam int TK = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       k_inc, k_dec, k_load;
  logic [3:0] sw;
  logic       run;
  logic [3:0] v15, v9;
  logic       chg15, chg9;

  int nvec = 0;
  int nmis = 0;
  int nchg;

  // model state: key index 0=inc 1=dec 2=load
  logic [2:0] sy1, sy2, lvl, pls;
  int         rl [3];
  int         mv [2];
  logic       mchg [2];
  int         mx [2] = '{15, 9};
  int         runlen;

  always #5 clk = ~clk;

  key_count_source #(
    .DEBOUNCE_CYCLES(DB), .MAX_VALUE(15), .TICK_CYCLES(TK)
  ) u15 (
    .CLOCK_50(clk), .Resetn(rst_n),
    .KEY_INC(k_inc), .KEY_DEC(k_dec), .KEY_LOAD(k_load),
    .SW(sw), .RUN(run), .V(v15), .CHG(chg15)
  );

  key_count_source #(
    .DEBOUNCE_CYCLES(DB), .MAX_VALUE(9), .TICK_CYCLES(TK)
  ) u9 (
    .CLOCK_50(clk), .Resetn(rst_n),
    .KEY_INC(k_inc), .KEY_DEC(k_dec), .KEY_LOAD(k_load),
    .SW(sw), .RUN(run), .V(v9), .CHG(chg9)
  );

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sy1 = '1; sy2 = '1; lvl = '1; pls = '0;
    for (int k = 0; k < 3; k++) rl[k] = 0;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0;
      mchg[i] = 1'b0;
    end
    runlen = 0;
  endtask

  // Called at each active edge with the inputs the DUT samples.
  task automatic model_step();
    logic [2:0] raw, nxt;
    logic       tick;
    int         nv;
    raw = {k_load, k_dec, k_inc};
    tick = 1'b0;
`ifdef KEY_COUNT_AUTO_RUN_EN
    runlen = run ? runlen + 1 : 0;
    tick = run && (runlen % TK == 0);
`endif
    for (int i = 0; i < 2; i++) begin
      nv = mv[i];
      if (pls[2]) nv = (int'(sw) > mx[i]) ? mx[i] : int'(sw);
      else if (pls[0] && pls[1]) nv = mv[i];
      else if (pls[0] || tick && !pls[1])
        nv = (mv[i] == mx[i]) ? 0 : mv[i] + 1;
      else if (pls[1]) nv = (mv[i] == 0) ? mx[i] : mv[i] - 1;
      mchg[i] = (nv != mv[i]);
      mv[i] = nv;
    end
    nxt = '0;
    for (int k = 0; k < 3; k++) begin
      if (sy2[k] != lvl[k]) begin
        rl[k]++;
        if (rl[k] == DB) begin
          lvl[k] = sy2[k];
          rl[k] = 0;
          nxt[k] = !sy2[k];
        end
      end else begin
        rl[k] = 0;
      end
    end
    sy2 = sy1;
    sy1 = raw;
    pls = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("v15", v15, 4'(mv[0]));
    chk("chg15", {3'b0, chg15}, {3'b0, mchg[0]});
    chk("v9", v9, 4'(mv[1]));
    chk("chg9", {3'b0, chg9}, {3'b0, mchg[1]});
  endtask

  task automatic set_key(int k, logic lv);
    case (k)
      0: k_inc = lv;
      1: k_dec = lv;
      default: k_load = lv;
    endcase
  endtask

  task automatic press(int k, int hold);
    set_key(k, 1'b0);
    repeat (hold) step();
    set_key(k, 1'b1);
    repeat (8) step();
  endtask

  initial begin
    rst_n = 1'b0;
    k_inc = 1'b1; k_dec = 1'b1; k_load = 1'b1;
    sw = 4'd0; run = 1'b0;
    model_reset();
    #1;
    chk("rst_v15", v15, 4'd0);
    chk("rst_chg15", {3'b0, chg15}, 4'd0);
    chk("rst_v9", v9, 4'd0);
    chk("rst_chg9", {3'b0, chg9}, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // clean press held 20 clocks
    k_inc = 1'b0;
    nchg = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (chg15) nchg++;
      if (i == 6) chk("inc_lat_pre", v15, 4'd0);
      if (i == 7) chk("inc_lat", v15, 4'd1);
    end
    chk("inc_once", v15, 4'd1);
    chk("inc_chg_once", 4'(nchg), 4'd1);
    k_inc = 1'b1;
    repeat (8) step();

    // bounce then stable low
    k_inc = 1'b0; step();
    k_inc = 1'b1; step();
    k_inc = 1'b0; step();
    k_inc = 1'b1; step();
    k_inc = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 6) chk("bounce_hold", v15, 4'd1);
    end
    chk("bounce_one", v15, 4'd2);
    k_inc = 1'b1;
    repeat (8) step();

    // saturating load and wraps
    sw = 4'd15; press(2, 10);
    chk("load15", v15, 4'd15);
    chk("load_sat9", v9, 4'd9);
    press(0, 10);
    chk("wrap_up15", v15, 4'd0);
    chk("wrap_up9", v9, 4'd0);
    press(1, 10);
    chk("wrap_dn15", v15, 4'd15);
    chk("wrap_dn9", v9, 4'd9);
    sw = 4'd12; press(2, 10);
    chk("load12", v15, 4'd12);
    chk("load12_sat9", v9, 4'd9);

    // coincident inc and dec cancel
    k_inc = 1'b0; k_dec = 1'b0;
    nchg = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 8) begin
        k_inc = 1'b1; k_dec = 1'b1;
      end
      if (chg15 || chg9) nchg++;
    end
    chk("incdec_v15", v15, 4'd12);
    chk("incdec_nochg", 4'(nchg), 4'd0);

    // load beats inc
    sw = 4'd5;
    k_load = 1'b0; k_inc = 1'b0;
    repeat (10) step();
    k_load = 1'b1; k_inc = 1'b1;
    repeat (8) step();
    chk("load_inc15", v15, 4'd5);
    chk("load_inc9", v9, 4'd5);

    // reset mid-debounce with dec still held
    sw = 4'd7; press(2, 10);
    chk("pre_rst", v15, 4'd7);
    k_dec = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst15", v15, 4'd0);
    chk("mid_rst9", v9, 4'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6) chk("rst_hold", v15, 4'd0);
    end
    chk("rst_fresh15", v15, 4'd15);
    chk("rst_fresh9", v9, 4'd9);
    k_dec = 1'b1;
    repeat (8) step();

`ifdef KEY_COUNT_AUTO_RUN_EN
    sw = 4'd14; press(2, 10);
    run = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 7) chk("run_pre", v15, 4'd14);
      if (i == 8) chk("run_t1", v15, 4'd15);
      if (i == 16) chk("run_t2", v15, 4'd0);
      if (i == 24) chk("run_t3", v15, 4'd1);
    end
    run = 1'b0;
    repeat (16) step();
    chk("run_frozen", v15, 4'd1);
`endif

    // random bouncy keys
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) k_inc = ~k_inc;
      if ($urandom_range(0, 7) == 0) k_dec = ~k_dec;
      if ($urandom_range(0, 11) == 0) k_load = ~k_load;
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
      if ($urandom_range(0, 40) == 0) run = ~run;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
